// File: rtl/nf_branch_redirect_ctrl.sv
// Branch redirect sequencer: captures a taken-branch target, hands it to fetch under req/ack, then flushes stale fetch data.
// Optional taken/not-taken statistics counters are built when NF_BRANCH_STAT_EN is defined.
module nf_branch_redirect_ctrl #(
  parameter int DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_valid,
  input  logic        pc_src,
  input  logic [31:0] br_target,
  input  logic        fetch_ack,
  output logic        pc_redir_en,
  output logic [31:0] pc_redir,
  output logic        flush_if,
  output logic        flush_id,
  output logic        stall_ex,
`ifdef NF_BRANCH_STAT_EN
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_ntaken_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  // Counter load value on acceptance; unused when the drain window is zero.
  localparam logic [3:0] DRAIN_INIT = (DRAIN_CYC == 0) ? 4'd0 : 4'(DRAIN_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid && pc_src) begin
          target_d = br_target;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        if (fetch_ack) begin
          if (DRAIN_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_redir_en = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    stall_ex    = 1'b0;
    busy        = 1'b0;
    pc_redir    = target_q;
    unique case (state_q)
      REDIRECT: begin
        pc_redir_en = 1'b1;
        flush_if    = 1'b1;
        flush_id    = 1'b1;
        stall_ex    = 1'b1;
        busy        = 1'b1;
      end
      DRAIN: begin
        flush_if = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        pc_redir_en = 1'b0;
      end
    endcase
  end

`ifdef NF_BRANCH_STAT_EN
  logic [31:0] br_taken_cnt_q, br_ntaken_cnt_q;
  logic        accept;

  // Only branches seen in IDLE are real; anything while busy is a flushed shadow.
  assign accept = (state_q == IDLE) && br_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_taken_cnt_q  <= 32'd0;
      br_ntaken_cnt_q <= 32'd0;
    end else if (accept) begin
      if (pc_src) begin
        if (br_taken_cnt_q != 32'hFFFF_FFFF) br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
      end else begin
        if (br_ntaken_cnt_q != 32'hFFFF_FFFF) br_ntaken_cnt_q <= br_ntaken_cnt_q + 32'd1;
      end
    end
  end

  assign br_taken_cnt  = br_taken_cnt_q;
  assign br_ntaken_cnt = br_ntaken_cnt_q;
`endif

endmodule

// File: tb/tb_nf_branch_redirect_ctrl.sv
// Self-checking bench for nf_branch_redirect_ctrl: two instances (drain window 2 and 0) against a cycle-level reference model.
module tb_nf_branch_redirect_ctrl;

  logic        clk;
  logic        resetn;
  logic        brValid;
  logic        pcSrc;
  logic [31:0] brTarget;
  logic        fetchAck;

  logic        redirEn [2];
  logic [31:0] redirPc [2];
  logic        flushIf [2];
  logic        flushId [2];
  logic        stallEx [2];
  logic        busyO   [2];
`ifdef NF_BRANCH_STAT_EN
  logic [31:0] takenCnt  [2];
  logic [31:0] nTakenCnt [2];
`endif

  int nCompared = 0;
  int nFail = 0;

  // Reference model: redirect pending flag, remaining drain cycles, captured target, statistics.
  int          drainLen [2] = '{2, 0};
  bit          mRedir   [2];
  int          mDrain   [2];
  logic [31:0] mTgt     [2];
  logic [31:0] mTaken   [2];
  logic [31:0] mNTaken  [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nf_branch_redirect_ctrl #(.DRAIN_CYC(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .br_valid(brValid), .pc_src(pcSrc),
    .br_target(brTarget), .fetch_ack(fetchAck),
    .pc_redir_en(redirEn[0]), .pc_redir(redirPc[0]), .flush_if(flushIf[0]),
    .flush_id(flushId[0]), .stall_ex(stallEx[0]),
`ifdef NF_BRANCH_STAT_EN
    .br_taken_cnt(takenCnt[0]), .br_ntaken_cnt(nTakenCnt[0]),
`endif
    .busy(busyO[0])
  );

  nf_branch_redirect_ctrl #(.DRAIN_CYC(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .br_valid(brValid), .pc_src(pcSrc),
    .br_target(brTarget), .fetch_ack(fetchAck),
    .pc_redir_en(redirEn[1]), .pc_redir(redirPc[1]), .flush_if(flushIf[1]),
    .flush_id(flushId[1]), .stall_ex(stallEx[1]),
`ifdef NF_BRANCH_STAT_EN
    .br_taken_cnt(takenCnt[1]), .br_ntaken_cnt(nTakenCnt[1]),
`endif
    .busy(busyO[1])
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mRedir[i]  = 1'b0;
      mDrain[i]  = 0;
      mTgt[i]    = 32'd0;
      mTaken[i]  = 32'd0;
      mNTaken[i] = 32'd0;
    end
  endtask

  // One rising edge worth of behaviour, written from the sequencing rules.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      if (mRedir[i]) begin
        if (fetchAck) begin
          mRedir[i] = 1'b0;
          mDrain[i] = drainLen[i];
        end
      end else if (mDrain[i] > 0) begin
        mDrain[i]--;
      end else if (brValid) begin
        if (pcSrc) begin
          mRedir[i] = 1'b1;
          mTgt[i]   = brTarget;
          if (mTaken[i] != 32'hFFFF_FFFF) mTaken[i]++;
        end else begin
          if (mNTaken[i] != 32'hFFFF_FFFF) mNTaken[i]++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < 2; i++) begin
      string t;
      t = $sformatf("%s/d%0d", tag, drainLen[i]);
      compare({t, ".pc_redir_en"}, 32'(redirEn[i]), 32'(mRedir[i]));
      compare({t, ".pc_redir"},    redirPc[i],      mTgt[i]);
      compare({t, ".flush_if"},    32'(flushIf[i]), 32'(mRedir[i] || mDrain[i] > 0));
      compare({t, ".flush_id"},    32'(flushId[i]), 32'(mRedir[i]));
      compare({t, ".stall_ex"},    32'(stallEx[i]), 32'(mRedir[i]));
      compare({t, ".busy"},        32'(busyO[i]),   32'(mRedir[i] || mDrain[i] > 0));
`ifdef NF_BRANCH_STAT_EN
      compare({t, ".taken_cnt"},   takenCnt[i],     mTaken[i]);
      compare({t, ".ntaken_cnt"},  nTakenCnt[i],    mNTaken[i]);
`endif
    end
  endtask

  task automatic applyStimulus(input string tag, input logic bv, input logic ps,
                               input logic [31:0] tgt, input logic ack);
    brValid  = bv;
    pcSrc    = ps;
    brTarget = tgt;
    fetchAck = ack;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    brValid  = 1'b0;
    pcSrc    = 1'b0;
    brTarget = 32'd0;
    fetchAck = 1'b0;
    resetn   = 1'b0;
    modelReset();

    // Reset holds everything at zero whatever the inputs do.
    for (int k = 0; k < 4; k++) begin
      brValid  = 1'($urandom);
      pcSrc    = 1'($urandom);
      brTarget = $urandom;
      fetchAck = 1'($urandom);
      @(posedge clk);
      #1;
      checkOutput("reset");
    end
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus("ntaken", 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("idle",   1'b0, 1'b0, 32'h0, 1'b0);

    // Taken branch with fetch_ack tied high.
    applyStimulus("imm.take", 1'b1, 1'b1, 32'h0000_0100, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus("imm.run", 1'b0, 1'b0, 32'h0, 1'b1);

    // Delayed acknowledge with a shadow taken branch during the wait.
    applyStimulus("dly.take", 1'b1, 1'b1, 32'h0000_2040, 1'b0);
    applyStimulus("dly.wait", 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("dly.shadow", 1'b1, 1'b1, 32'h0000_9999, 1'b0);
    applyStimulus("dly.wait", 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus("dly.wait", 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("dly.ack",  1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back: a taken branch offered every cycle with ack high.
    for (int k = 0; k < 8; k++)
      applyStimulus("b2b", 1'b1, 1'b1, 32'h0000_3000 + 32'(k * 4), 1'b1);

    // Asynchronous reset while a redirect is outstanding.
    applyStimulus("mid.settle", 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("mid.settle", 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus("mid.take", 1'b1, 1'b1, 32'h0000_4444, 1'b0);
    #2;
    resetn = 1'b0;
    modelReset();
    #1;
    checkOutput("mid.async");
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus("mid.retake", 1'b1, 1'b1, 32'h0000_5550, 1'b0);
    applyStimulus("mid.ack",    1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++)
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, 1'($urandom_range(0, 3) == 0));

`ifdef NF_BRANCH_STAT_EN
    // Saturation of the taken counter.
    for (int k = 0; k < 4; k++) applyStimulus("sat.quiet", 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    force u_dut2.br_taken_cnt_q = 32'hFFFF_FFFE;
    force u_dut0.br_taken_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut2.br_taken_cnt_q;
    release u_dut0.br_taken_cnt_q;
    mTaken[0] = 32'hFFFF_FFFE;
    mTaken[1] = 32'hFFFF_FFFE;
    for (int k = 0; k < 12; k++) applyStimulus("sat", 1'b1, 1'b1, 32'h0000_6000, 1'b1);
    compare("sat.final.d2", takenCnt[0], 32'hFFFF_FFFF);
    compare("sat.final.d0", takenCnt[1], 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule

// File: doc/nf_branch_redirect_ctrl.md
# nf_branch_redirect_ctrl

Sequencing controller for the branch unit's resolution result. Sits between the branch unit (execute stage) and the fetch stage/pipeline registers. On a taken branch it captures the target, drives a PC redirect to fetch under a request/acknowledge handshake, stalls execute until fetch accepts, and then flushes stale fetch responses for a fixed drain window. One redirect is in flight at a time; branches arriving while busy are ignored, since the flushed pipeline cannot legally produce them.

## Interface
- DRAIN_CYC, default 2: cycles of post-acceptance flush covering in-flight fetch responses; legal range 0..15.
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- br_valid  in  1  branch instruction resolved in execute this cycle (branch_type qualified by stage valid).
- pc_src  in  1  branch unit taken result; meaningful only with br_valid.
- br_target  in  32  branch target address from execute.
- fetch_ack  in  1  fetch accepted the redirect this cycle.
- pc_redir_en  out  1  redirect request to fetch.
- pc_redir  out  32  redirect address, stable while pc_redir_en=1.
- flush_if  out  1  kill the IF/ID register and discard returning fetch data.
- flush_id  out  1  kill the ID/EX register.
- stall_ex  out  1  hold the execute stage.
- busy  out  1  controller is not in IDLE.
- br_taken_cnt  out  32  taken-branch count; present only with NF_BRANCH_STAT_EN.
- br_ntaken_cnt  out  32  not-taken-branch count; present only with NF_BRANCH_STAT_EN.

## Operation
- States: IDLE, REDIRECT, DRAIN; 2-bit state register plus a 4-bit drain counter and a 32-bit target register.
- IDLE: if br_valid=1 and pc_src=1, latch br_target into the target register and go to REDIRECT. br_valid=1 with pc_src=0 causes no state change.
- REDIRECT: pc_redir_en=1, pc_redir=latched target, flush_if=1, flush_id=1, stall_ex=1.
  - If fetch_ack=1: go to DRAIN with counter=DRAIN_CYC-1, or go to IDLE when DRAIN_CYC=0.
  - If fetch_ack=0: stay in REDIRECT and hold all outputs.
- DRAIN: flush_if=1; flush_id=0; stall_ex=0; pc_redir_en=0. Decrement the counter each cycle; at counter=0 go to IDLE on the next edge.
- br_valid is ignored in REDIRECT and DRAIN, including for statistics.
- The target is passed through unmodified. Alignment checking belongs to fetch.
- Outputs are decoded from the state register only (Moore). pc_redir is driven from the target register in every state and reads 0 after reset until the first capture.
- busy=1 in REDIRECT and DRAIN.

## Timing
- Reset: state=IDLE, target register=0, counter=0, counters=0, all 1-bit outputs=0. Asserting resetn=0 mid-redirect aborts to IDLE immediately (asynchronous) and drops pc_redir_en the same cycle.
- Taken branch sampled at edge N: pc_redir_en, flush_if, flush_id and stall_ex are high from after edge N.
- fetch_ack sampled at edge M: pc_redir_en drops after edge M. DRAIN then lasts exactly DRAIN_CYC cycles, and IDLE is reached after edge M+DRAIN_CYC.
- fetch_ack in the same cycle REDIRECT is entered is legal; the minimum REDIRECT duration is 1 cycle.
- fetch_ack outside REDIRECT is ignored.
- A taken branch in the IDLE cycle that immediately follows DRAIN is accepted normally. There is no dead cycle.

## Configuration
- NF_BRANCH_STAT_EN defined: br_taken_cnt and br_ntaken_cnt exist.
  - Each counts branches accepted in IDLE (br_valid=1 with pc_src=1 or 0 respectively).
  - Each saturates at 32'hFFFF_FFFF and resets to 0.
- NF_BRANCH_STAT_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset: resetn=0 with random inputs → all outputs 0, busy=0. Release, then br_valid=1/pc_src=0 → no redirect; with stats, br_ntaken_cnt=1.
- Taken, immediate ack (DRAIN_CYC=2): branch to 0x0000_0100, fetch_ack tied 1 → pc_redir_en high 1 cycle with pc_redir=0x100, then flush_if for 2 more cycles, then busy=0.
- Delayed ack: branch to 0x0000_2040, fetch_ack after 5 cycles → stall_ex and pc_redir_en held 5 cycles with a constant address; a second taken branch during the wait is ignored.
- Back-to-back: taken branch on the first IDLE cycle after DRAIN → a new redirect with the new target, no lost cycle. With DRAIN_CYC=0, the return to IDLE immediately follows ack.
- Reset mid-op: resetn=0 during REDIRECT → pc_redir_en=0 asynchronously; after release the controller is in IDLE and accepts a new branch.
- Stats saturation (macro on): force br_taken_cnt to 0xFFFF_FFFE, issue 3 taken branches → reads 0xFFFF_FFFF.
